pipeline_ctrl: RTL and testbench

Central hazard and pipeline-control unit for the 5-stage RISC-V core. It produces the `{flush, stall}` pairs consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and it drives PC stall/redirect. It resolves memory-wait freezes, taken-branch redirects (including redirects deferred behind an outstanding instruction fetch) and load-use stalls, and it keeps a saturating stall-cycle counter.

---
 rtl/pipeline_ctrl.sv | 100 ++++++++++
 tb/tb_pipeline_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/flush/stall control for the 5-stage core with deferred redirect and stall counter
module pipeline_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_busy,
    input  logic                  mem_busy,
    input  logic [4:0]            id_rs1_addr,
    input  logic [4:0]            id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rd_addr,
    input  logic                  ex_branch_taken,
    input  logic [ADDR_WIDTH-1:0] ex_branch_target,
    output logic                  pc_stall,
    output logic                  pc_redirect,
    output logic [ADDR_WIDTH-1:0] pc_redirect_target,
    output logic [1:0]            ifid_fs,
    output logic [1:0]            idex_fs,
    output logic [1:0]            exmem_fs,
    output logic [1:0]            memwb_fs,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);
    typedef enum logic {RUN, REDIR_PEND} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pend_target;
    logic                  load_use;

    assign load_use = ex_mem_read && ex_rd_addr != 5'd0 &&
                      ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
                       (id_rs2_used && id_rs2_addr == ex_rd_addr));

    // Prioritised control decode: reset, memory freeze, branch, pending redirect, load-use, fetch wait
    always_comb begin
        pc_stall           = 1'b0;
        pc_redirect        = 1'b0;
        pc_redirect_target = pend_target;
        ifid_fs            = 2'b00;
        idex_fs            = 2'b00;
        exmem_fs           = 2'b00;
        memwb_fs           = 2'b00;
        if (!reset_n) begin
            pc_stall = 1'b1;
            ifid_fs  = 2'b10;
            idex_fs  = 2'b10;
            exmem_fs = 2'b10;
            memwb_fs = 2'b10;
        end else if (mem_busy) begin
            pc_stall = 1'b1;
            ifid_fs  = 2'b01;
            idex_fs  = 2'b01;
            exmem_fs = 2'b01;
            memwb_fs = 2'b10;
        end else if (state == RUN && ex_branch_taken) begin
            pc_redirect        = !if_busy;
            pc_redirect_target = if_busy ? pend_target : ex_branch_target;
            pc_stall           = if_busy;
            ifid_fs            = 2'b10;
            idex_fs            = 2'b10;
        end else if (state == REDIR_PEND) begin
            pc_redirect = !if_busy;
            pc_stall    = if_busy;
            ifid_fs     = 2'b10;
        end else if (load_use) begin
            pc_stall = 1'b1;
            ifid_fs  = 2'b01;
            idex_fs  = 2'b10;
        end else if (if_busy) begin
            pc_stall = 1'b1;
            ifid_fs  = 2'b10;
        end
    end

    // Redirect FSM: park a taken-branch target while a fetch is outstanding, release it once IF is idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            pend_target <= '0;
        end else if (!mem_busy) begin
            if (state == RUN && ex_branch_taken && if_busy) begin
                state       <= REDIR_PEND;
                pend_target <= ex_branch_target;
            end else if (state == REDIR_PEND && !if_busy) begin
                state <= RUN;
            end
        end
    end

    // Saturating count of PC-stall cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cycles <= '0;
        else if (pc_stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_busy, mem_busy, id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic [31:0] ex_branch_target;
    logic        pc_stall, pc_redirect;
    logic [31:0] pc_redirect_target;
    logic [1:0]  ifid_fs, idex_fs, exmem_fs, memwb_fs;
    logic [3:0]  stall_cycles;

    typedef struct {
        logic [45:0] v;
        string       n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    pipeline_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .if_busy(if_busy), .mem_busy(mem_busy),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .pc_stall(pc_stall), .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
        .ifid_fs(ifid_fs), .idex_fs(idex_fs), .exmem_fs(exmem_fs), .memwb_fs(memwb_fs),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Monitor: compare each cycle's outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [45:0] act;
            e = q.pop_front();
            act = {pc_stall, pc_redirect, pc_redirect_target, ifid_fs, idex_fs, exmem_fs, memwb_fs, stall_cycles};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got stall=%b redir=%b tgt=%h fs=%b_%b_%b_%b cnt=%h, want stall=%b redir=%b tgt=%h fs=%b_%b_%b_%b cnt=%h",
                         e.n, act[45], act[44], act[43:12], act[11:10], act[9:8], act[7:6], act[5:4], act[3:0],
                         e.v[45], e.v[44], e.v[43:12], e.v[11:10], e.v[9:8], e.v[7:6], e.v[5:4], e.v[3:0]);
            end
        end
    end

    task automatic clr();
        if_busy = 0; mem_busy = 0; id_rs1_used = 0; id_rs2_used = 0; ex_mem_read = 0;
        ex_branch_taken = 0; id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0; ex_branch_target = 0;
    endtask

    task automatic step(input string n, input logic ps, input logic pr, input logic [31:0] t,
                        input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                        input logic [1:0] d, input logic [3:0] cnt);
        exp_t e;
        e.v = {ps, pr, t, a, b, c, d, cnt};
        e.n = n;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            {if_busy, mem_busy, id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken} = 6'($urandom);
            id_rs1_addr = 5'($urandom); id_rs2_addr = 5'($urandom); ex_rd_addr = 5'($urandom);
            ex_branch_target = $urandom;
            step("reset_hold", 1, 0, 0, 2'b10, 2'b10, 2'b10, 2'b10, 0);
        end
        clr(); reset_n = 1;
        step("reset_release", 0, 0, 0, 0, 0, 0, 0, 0);
        ex_mem_read = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_rs2_used = 1;
        step("load_use", 1, 0, 0, 2'b01, 2'b10, 0, 0, 0);
        clr();
        step("load_use_after", 0, 0, 0, 0, 0, 0, 0, 1);
        ex_mem_read = 1; ex_rd_addr = 0; id_rs2_addr = 0; id_rs2_used = 1;
        step("load_use_rd0", 0, 0, 0, 0, 0, 0, 0, 1);
        ex_mem_read = 1; ex_rd_addr = 7; id_rs1_addr = 7; id_rs1_used = 0; id_rs2_addr = 3; id_rs2_used = 1;
        step("load_use_rs1_unused", 0, 0, 0, 0, 0, 0, 0, 1);
        id_rs1_used = 1;
        step("load_use_rs1", 1, 0, 0, 2'b01, 2'b10, 0, 0, 1);
        clr();
        ex_branch_taken = 1; ex_branch_target = 32'h8000_0100;
        ex_mem_read = 1; ex_rd_addr = 4; id_rs1_addr = 4; id_rs1_used = 1;
        step("redirect_now", 0, 1, 32'h8000_0100, 2'b10, 2'b10, 0, 0, 2);
        clr();
        step("after_redirect", 0, 0, 0, 0, 0, 0, 0, 2);
        ex_branch_taken = 1; ex_branch_target = 32'h8000_0200; if_busy = 1;
        step("defer_entry", 1, 0, 0, 2'b10, 2'b10, 0, 0, 2);
        clr(); if_busy = 1;
        step("defer_wait1", 1, 0, 32'h8000_0200, 2'b10, 0, 0, 0, 3);
        step("defer_wait2", 1, 0, 32'h8000_0200, 2'b10, 0, 0, 0, 4);
        if_busy = 0; mem_busy = 1;
        step("defer_freeze", 1, 0, 32'h8000_0200, 2'b01, 2'b01, 2'b01, 2'b10, 5);
        clr();
        step("defer_issue", 0, 1, 32'h8000_0200, 2'b10, 0, 0, 0, 6);
        step("back_in_run", 0, 0, 32'h8000_0200, 0, 0, 0, 0, 6);
        for (int i = 0; i < 4; i++) begin
            mem_busy = 1; ex_branch_taken = 1; ex_branch_target = 32'h8000_0300;
            step("mem_freeze", 1, 0, 32'h8000_0200, 2'b01, 2'b01, 2'b01, 2'b10, 4'(6 + i));
        end
        mem_busy = 0;
        step("freeze_then_redirect", 0, 1, 32'h8000_0300, 2'b10, 2'b10, 0, 0, 10);
        clr();
        step("after_freeze", 0, 0, 32'h8000_0200, 0, 0, 0, 0, 10);
        for (int i = 0; i < 20; i++) begin
            if_busy = 1;
            step("saturate", 1, 0, 32'h8000_0200, 2'b10, 0, 0, 0, (10 + i > 15) ? 4'hF : 4'(10 + i));
        end
        ex_branch_taken = 1; ex_branch_target = 32'h8000_0400;
        step("pend_again", 1, 0, 32'h8000_0200, 2'b10, 2'b10, 0, 0, 4'hF);
        ex_branch_taken = 0;
        step("pend_wait", 1, 0, 32'h8000_0400, 2'b10, 0, 0, 0, 4'hF);
        reset_n = 0;
        step("reset_mid_pend", 1, 0, 0, 2'b10, 2'b10, 2'b10, 2'b10, 0);
        clr(); reset_n = 1;
        step("no_redirect_after_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        step("still_run", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
